mem_arbiter: RTL and testbench

Two-port arbiter sharing one single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). It serialises requests, holds each on the memory bus until the memory acknowledges, and returns data with a one-cycle ready pulse. It also discards in-flight fetches on redirect (jump taken) and bounds memory wait time with a timeout.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_wait_counter.sv | 32 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port ids
// and the instruction word returned when a fetch times out.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/arb_wait_counter.sv
// Cycle counter bounding how long a granted access may wait for mem_ready.
// o_tc is asserted while the count sits at TIMEOUT-1.
module arb_wait_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == TC_VAL);
    assign o_tc = w_tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-stage requests onto one single-ported memory,
// with round-robin tie-break, fetch discard on redirect, and a wait timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_drop;
    logic              r_i_ready;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_ready;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_req;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_err;

    logic w_busy;
    logic w_tc;
    logic w_done;
    logic w_grant_d;
    logic w_discard;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_done    = mem_ready || w_tc;
    assign w_grant_d = d_req && (!i_req || (r_last == PORT_I));
    // A flush arriving in the completion cycle itself must also discard.
    assign w_discard = r_drop || i_flush;

    arb_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_busy),
        .i_inc (w_busy && !mem_ready),
        .o_tc  (w_tc)
    );

    // Redirect in the pulse cycle hides a fetch the pipeline no longer wants.
    assign i_ready   = r_i_ready && !i_flush;
    assign i_rdata   = r_i_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_last      <= PORT_I;
            r_drop      <= 1'b0;
            r_i_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= ST_BUSY_D;
                        r_last      <= PORT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= d_wr;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (i_req) begin
                        r_state     <= ST_BUSY_I;
                        r_last      <= PORT_I;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                    end
                end
                ST_BUSY_I: begin
                    if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        if (!mem_ready) begin
                            r_err <= 1'b1;
                        end
                        if (!w_discard) begin
                            r_i_ready <= 1'b1;
                            r_i_rdata <= mem_ready ? mem_rdata : DATA_W'(NOP_INSN);
                        end
                    end
                end
                ST_BUSY_D: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_d_ready <= 1'b1;
                        r_d_rdata <= mem_ready ? mem_rdata : '0;
                        if (!mem_ready) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and both
// requesters, with cycle-exact expected values written out by hand.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int n_checks;
    int n_fails;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        i_flush   = 1'b0;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_i_ready", {31'd0, i_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_err",     {31'd0, err},     32'd0);
        check("rst_i_rdata", i_rdata,          32'd0);
        rst = 1'b1;

        // Single fetch, memory answers on the third mem_req cycle
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check("f1_mem_req",  {31'd0, mem_req}, 32'd1);
        check("f1_mem_addr", mem_addr,         32'h100);
        check("f1_mem_wr",   {31'd0, mem_wr},  32'd0);
        step();
        step();
        check("f1_wait_rdy", {31'd0, i_ready}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        step();
        mem_ready = 1'b0; i_req = 1'b0;
        check("f1_i_ready",  {31'd0, i_ready}, 32'd1);
        check("f1_i_rdata",  i_rdata,          32'hCAFE_0001);
        check("f1_req_low",  {31'd0, mem_req}, 32'd0);
        step();
        check("f1_pulse1",   {31'd0, i_ready}, 32'd0);

        // Tie after reset: data write wins, then alternation favours fetch
        do_reset();
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        step();
        check("t1_mem_wr",    {31'd0, mem_wr}, 32'd1);
        check("t1_mem_addr",  mem_addr,        32'h200);
        check("t1_mem_wdata", mem_wdata,       32'hDEAD_BEEF);
        mem_ready = 1'b1; mem_rdata = 32'h0;
        step();
        check("t1_d_ready",   {31'd0, d_ready}, 32'd1);
        check("t1_i_ready",   {31'd0, i_ready}, 32'd0);
        mem_ready = 1'b0;
        d_wr = 1'b0; d_addr = 32'h204; d_wdata = '0;
        step();
        check("t2_fetch_addr",  mem_addr,         32'h300);
        check("t2_fetch_wr",    {31'd0, mem_wr},  32'd0);
        check("t2_fetch_wdata", mem_wdata,        32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        check("t2_i_ready",   {31'd0, i_ready}, 32'd1);
        check("t2_i_rdata",   i_rdata,          32'h1111_1111);
        mem_ready = 1'b0; i_req = 1'b0;
        step();
        check("t3_data_addr", mem_addr,        32'h204);
        check("t3_data_wr",   {31'd0, mem_wr}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h2222_2222;
        step();
        check("t3_d_ready",   {31'd0, d_ready}, 32'd1);
        check("t3_d_rdata",   d_rdata,          32'h2222_2222);
        mem_ready = 1'b0; d_req = 1'b0;
        step();

        // Flush one cycle after grant drops the fetch
        i_req = 1'b1; i_addr = 32'h80;
        step();
        check("fl_mem_addr", mem_addr, 32'h80);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
        step();
        check("fl_no_ready", {31'd0, i_ready}, 32'd0);
        check("fl_req_low",  {31'd0, mem_req}, 32'd0);
        check("fl_rdata_kept", i_rdata, 32'h1111_1111);
        mem_ready = 1'b0; i_addr = 32'h40;
        step();
        check("fl2_mem_addr", mem_addr, 32'h40);
        mem_ready = 1'b1; mem_rdata = 32'h4444_4444;
        step();
        check("fl2_i_ready", {31'd0, i_ready}, 32'd1);
        check("fl2_i_rdata", i_rdata,          32'h4444_4444);
        mem_ready = 1'b0; i_req = 1'b0;
        step();

        // Flush in the pulse cycle hides the pulse
        i_req = 1'b1; i_addr = 32'h50;
        step();
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ready = 1'b0; i_req = 1'b0; i_flush = 1'b1;
        #1;
        check("flp_no_ready", {31'd0, i_ready}, 32'd0);
        i_flush = 1'b0;
        step();

        // Timeout: eight BUSY cycles without mem_ready
        i_req = 1'b1; i_addr = 32'h60;
        step();
        for (int unsigned k = 0; k < 7; k++) step();
        check("to_still_busy", {31'd0, mem_req}, 32'd1);
        check("to_no_early",   {31'd0, i_ready}, 32'd0);
        check("to_err_pre",    {31'd0, err},     32'd0);
        step();
        i_req = 1'b0;
        check("to_i_ready",  {31'd0, i_ready}, 32'd1);
        check("to_i_rdata",  i_rdata,          32'h0000_0013);
        check("to_err",      {31'd0, err},     32'd1);
        check("to_req_low",  {31'd0, mem_req}, 32'd0);
        step();
        step();
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Stray mem_ready while idle
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        step();
        check("st_i_ready", {31'd0, i_ready}, 32'd0);
        check("st_d_ready", {31'd0, d_ready}, 32'd0);
        check("st_mem_req", {31'd0, mem_req}, 32'd0);
        mem_ready = 1'b0;

        // Reset in the middle of a data read
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h210;
        step();
        check("rm_busy", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("rm_mem_req", {31'd0, mem_req}, 32'd0);
        check("rm_err",     {31'd0, err},     32'd0);
        d_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rm_no_ready", {31'd0, d_ready}, 32'd0);
        d_req = 1'b1; d_addr = 32'h214;
        step();
        check("rm2_mem_addr", mem_addr, 32'h214);
        mem_ready = 1'b1; mem_rdata = 32'h6666_6666;
        step();
        check("rm2_d_ready", {31'd0, d_ready}, 32'd1);
        check("rm2_d_rdata", d_rdata,          32'h6666_6666);
        mem_ready = 1'b0; d_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
